// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding,
// parity mode constants and the parity-bit generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Parity bit for a zero-extended data word; unused upper bits must be 0.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic ones;
    ones = ^data;
    case (mode)
      PAR_ODD:  parity_bit = ~ones;
      PAR_EVEN: parity_bit = ones;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO for the transmit path. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate flag.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // full is derived from the current pointers, so a same-cycle pop never
  // makes room for a write that arrives while full.
  assign count   = wr_ptr_r - rd_ptr_r;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign wr_ok_s = wr && !full;
  assign rd_ok_s = rd && !empty;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array write; data needs no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Read and write pointer advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO and CTS-style flow control.
// Frame: start, DATA_BITS data LSB first, optional parity, STOP_BITS stops.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_in_wr,
  input  logic                          tx_enable,
  output logic                          uart_tx,
  output logic                          busy_tx,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  import uart_pkg::*;

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

  generate
    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
      $error("uart_tx_fifo: illegal parameter combination");
    end
  endgenerate

  tx_state_t            state_r;
  logic [CNT_W-1:0]     baud_cnt_r;
  logic [2:0]           bit_idx_r;
  logic                 stop_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_r;
  logic                 uart_tx_r;
  logic                 overflow_r;

  logic                 pop_s;
  logic                 fifo_empty_s;
  logic [DATA_BITS-1:0] head_s;
  logic                 start_ok_s;
  logic                 tick_s;
  logic                 last_stop_s;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (data_in_wr),
    .wr_data (data_in),
    .rd      (pop_s),
    .rd_data (head_s),
    .full    (full),
    .empty   (fifo_empty_s),
    .count   (fifo_count)
  );

  assign start_ok_s  = !fifo_empty_s && tx_enable;
  assign tick_s      = (baud_cnt_r == '0);
  assign last_stop_s = (stop_idx_r == 1'(STOP_BITS - 1));
  assign uart_tx     = uart_tx_r;
  assign overflow    = overflow_r;
  assign busy_tx     = (state_r != IDLE) || !fifo_empty_s;

  // Pop the FIFO head when a frame starts from idle or chains after a stop bit.
  always_comb begin
    pop_s = 1'b0;
    if (state_r == IDLE) begin
      pop_s = start_ok_s;
    end else if (state_r == STOP && tick_s && last_stop_s) begin
      pop_s = start_ok_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Flag a write that arrived while the FIFO was full (word is dropped).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= data_in_wr && full;
    end
  end

  // Transmit FSM with baud counter, bit counters and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= DIV_M1;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= '0;
      par_r      <= 1'b0;
      uart_tx_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          baud_cnt_r <= DIV_M1;
          if (start_ok_s) begin
            shift_r   <= head_s;
            par_r     <= parity_bit(8'(head_s), PARITY);
            uart_tx_r <= 1'b0;
            state_r   <= START;
          end else begin
            uart_tx_r <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            baud_cnt_r <= DIV_M1;
            uart_tx_r  <= shift_r[0];
            shift_r    <= shift_r >> 1;
            bit_idx_r  <= 3'd0;
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r - CNT_W'(1);
          end
        end
        DATA: begin
          if (tick_s) begin
            baud_cnt_r <= DIV_M1;
            if (bit_idx_r == 3'(DATA_BITS - 1)) begin
              if (PARITY != PAR_NONE) begin
                uart_tx_r <= par_r;
                state_r   <= uart_pkg::PARITY;
              end else begin
                uart_tx_r  <= 1'b1;
                stop_idx_r <= 1'b0;
                state_r    <= STOP;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              uart_tx_r <= shift_r[0];
              shift_r   <= shift_r >> 1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - CNT_W'(1);
          end
        end
        uart_pkg::PARITY: begin
          if (tick_s) begin
            baud_cnt_r <= DIV_M1;
            uart_tx_r  <= 1'b1;
            stop_idx_r <= 1'b0;
            state_r    <= STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r - CNT_W'(1);
          end
        end
        STOP: begin
          if (tick_s) begin
            baud_cnt_r <= DIV_M1;
            if (last_stop_s) begin
              // Chain straight into the next start bit when allowed.
              if (start_ok_s) begin
                shift_r   <= head_s;
                par_r     <= parity_bit(8'(head_s), PARITY);
                uart_tx_r <= 1'b0;
                state_r   <= START;
              end else begin
                uart_tx_r <= 1'b1;
                state_r   <= IDLE;
              end
            end else begin
              stop_idx_r <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - CNT_W'(1);
          end
        end
        default: begin
          baud_cnt_r <= DIV_M1;
          uart_tx_r  <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO and run-time flow control. It serialises words written by the host-side bus logic onto a single RS232 TX line. Frame format and bit rate are fixed at elaboration: data width, parity, stop bits, clock and baud. The FIFO lets the host burst several characters without polling `busy_tx` between them.

## Interface
- `CLK_HZ`, 50000000: input clock frequency in Hz.
- `BAUD`, 115200: bit rate. `DIV = CLK_HZ/BAUD` (truncating). `DIV < 2` is an elaboration error.
- `DATA_BITS`, 8: data bits per frame, legal range 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of 2 and ≥ 2.
- `clk` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `data_in` input `DATA_BITS`: word to transmit.
- `data_in_wr` input 1: write strobe, one word per cycle.
- `tx_enable` input 1: flow control (CTS). 0 holds off the start of new frames.
- `uart_tx` output 1: serial line, registered, idle high.
- `busy_tx` output 1: `state != IDLE || fifo_count != 0`.
- `full` output 1: FIFO full. Writes are rejected while asserted.
- `fifo_count` output `$clog2(FIFO_DEPTH)+1`: number of occupied entries.
- `overflow` output 1: one-cycle pulse when `data_in_wr && full`. The word is dropped.

## Operation
- FIFO write: `data_in_wr && !full`. Entry is visible and `fifo_count` incremented after the same edge.
- `full` is evaluated before any same-cycle pop. A write while full is always dropped, even if a pop occurs that cycle.
- Simultaneous accepted write and pop leaves `fifo_count` unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when `fifo_count != 0 && tx_enable`. On that edge:
  - pop the FIFO head into the shift register;
  - set `uart_tx <= 0`;
  - load the baud counter with `DIV-1`.
- The baud counter decrements every clock. At 0 it reloads `DIV-1` and advances the bit, so every bit is exactly `DIV` clocks.
- START → DATA. DATA sends `DATA_BITS` bits, LSB first, using a bit-index counter.
- DATA → PARITY if `PARITY != 0`, otherwise DATA → STOP.
- PARITY bit value:
  - odd: total ones in data plus parity is odd;
  - even: total ones in data plus parity is even.
- STOP drives 1 for `STOP_BITS` bit periods.
- End of last stop bit:
  - FIFO non-empty and `tx_enable` = 1: go directly to START. No idle gap; the pop and `uart_tx <= 0` happen on that edge.
  - otherwise: go to IDLE with `uart_tx = 1`.
- `tx_enable` is sampled only in IDLE and at the end of the last stop bit. Deasserting it mid-frame never truncates the frame.
- Baud counter is free of state in IDLE: held at `DIV-1`.

## Timing
- Reset values: `uart_tx` = 1, `busy_tx` = 0, `full` = 0, `fifo_count` = 0, `overflow` = 0, FSM in IDLE, FIFO pointers 0.
- Latency: `data_in_wr` sampled at edge E0 into an empty FIFO in IDLE with `tx_enable` = 1 → `uart_tx` falls after edge E1.
- Frame length: `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV` clocks.
- `busy_tx` rises after the accepting write edge. It falls on the edge the FSM enters IDLE with the FIFO empty.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The frame is aborted and queued words are discarded.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic[2:0] tx_state_t` {IDLE, START, DATA, PARITY, STOP};
  - parity encoding constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`.
- Sub-module `uart_fifo`: synchronous FIFO, parameters `WIDTH` and `DEPTH`. Provides wr/rd/full/empty/count. Asynchronous reset; pointers are one bit wider than the address.
- Top level contains the FSM, baud counter, bit counter, shift register and parity generator.

## Test plan
All scenarios use `CLK_HZ` = 1000, `BAUD` = 100 (`DIV` = 10) unless noted.
- 8N1, write 0xA5 → `uart_tx` low 2 clocks after the write cycle. Then 1,0,1,0,0,1,0,1 at 10 clocks each, stop high 10 clocks. `busy_tx` = 0 exactly 100 clocks after the falling start edge.
- `DATA_BITS` = 7, write 0x41: even parity → parity bit 0; odd parity → parity bit 1. Frame length 100 clocks with 1 stop bit.
- `FIFO_DEPTH` = 4, `tx_enable` = 0, write 0x11..0x55 in 5 consecutive cycles → `full` after the 4th write, `overflow` pulse on the 5th, `fifo_count` = 4. Then set `tx_enable` = 1 → 4 frames 0x11..0x44 back-to-back with no idle clocks between them.
- `STOP_BITS` = 2, write 0x00 then 0xFF → line high exactly 20 clocks between the last data bit of frame 1 and the start bit of frame 2.
- Drop `tx_enable` during data bit 3 with 2 words queued → current frame completes intact, line stays high and `fifo_count` = 1 until `tx_enable` returns.
- Assert `reset` during data bit 3 with 3 words queued → `uart_tx` = 1 and `fifo_count` = 0 in the same cycle. No frame follows reset release.
